// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and helpers for the multi-channel tick generator.
package tick_gen_pkg;
   localparam int TG_W       = 20;
   localparam int TG_DEF_DIV = 200000;
   localparam int MIN_DIV    = 2;

   function automatic logic [31:0] sq_thresh(input logic [31:0] div);
      return div >> 1;
   endfunction
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one divider channel with a deferred divisor update, registered tick pulse and square wave.
module tick_chan import tick_gen_pkg::*; #(
   parameter int W       = TG_W,
   parameter int DEF_DIV = TG_DEF_DIV
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sync,
   input  logic         wr,
   input  logic [W-1:0] wr_div,
   output logic         tick,
   output logic         sq
);
   logic [W-1:0] cnt_q, cnt_d, div_q, div_d, pend_div_q, pend_div_d;
   logic         pend_v_q, pend_v_d, tick_q, tick_d, sq_q, sq_d;
   logic         wrap, apply;

   always_comb begin
      // >= keeps a counter left above a freshly shrunk divisor from running to overflow
      wrap       = en && (cnt_q >= div_q - W'(1));
      apply      = wrap || !en || sync;
      cnt_d      = (sync || wrap) ? '0 : en ? cnt_q + W'(1) : cnt_q;
      tick_d     = wrap && !sync;
      sq_d       = en ? (32'(cnt_q) < sq_thresh(32'(div_q))) : sq_q;
      div_d      = (wr && apply) ? wr_div : (apply && pend_v_q) ? pend_div_q : div_q;
      pend_div_d = wr ? wr_div : pend_div_q;
      pend_v_d   = (wr || pend_v_q) && !apply;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         div_q      <= W'(DEF_DIV);
         pend_div_q <= W'(DEF_DIV);
         pend_v_q   <= 1'b0;
         tick_q     <= 1'b0;
         sq_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_v_q   <= pend_v_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: CH independently programmable clock dividers with common sync and
// write validation; rejected divisor writes raise a one-cycle cfg_err.
module tick_gen_multi import tick_gen_pkg::*; #(
   parameter int  CH      = 4,
   parameter int  W       = TG_W,
   parameter int  DEF_DIV = TG_DEF_DIV,
   localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] en,
   input  logic          sync,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [W-1:0]  cfg_div,
   output logic [CH-1:0] tick,
   output logic [CH-1:0] sq,
   output logic          cfg_err
);
   logic accept, cfg_err_d, cfg_err_q;

   always_comb begin
      accept    = cfg_we && (32'(cfg_ch) < 32'(CH)) && (cfg_div >= W'(MIN_DIV));
      cfg_err_d = cfg_we && !accept;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cfg_err_q <= 1'b0;
      else      cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      tick_chan #(.W(W), .DEF_DIV(DEF_DIV)) u_chan (
         .clk    (clk),
         .rst    (rst),
         .en     (en[i]),
         .sync   (sync),
         .wr     (accept && (cfg_ch == CW'(i))),
         .wr_div (cfg_div),
         .tick   (tick[i]),
         .sq     (sq[i])
      );
   end
endmodule
